// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith/shift ops plus
// iterative unsigned multiply (shift-add) and restoring divide.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Out_hi,
  output logic             OFL,
  output logic             Zero,
  output logic             DZ,
  output logic             Illegal
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q;
  logic             is_div_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] out_q, out_hi_q;
  logic             ofl_q, zero_q, dz_q, ill_q;

  logic             accept, is_it, last;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sc_out;
  logic             sc_ofl, sc_ill;
  logic [WIDTH:0]   mul_sum, div_t;
  logic [WIDTH-1:0] div_s, hi_n, lo_n;

  assign accept = in_valid && (state_q == IDLE);
  assign is_it  = (Op == 4'd10) || (Op == 4'd11);
  assign last   = (cnt_q == '0);

  always_comb begin
    sh     = B[SHW-1:0];
    add_w  = {1'b0, A} + {1'b0, B};
    sub_w  = {1'b0, B} + {1'b0, ~A} + (WIDTH+1)'(1);
    sc_out = '0;
    sc_ofl = 1'b0;
    sc_ill = 1'b0;
    case (Op)
      4'd0: begin
        sc_out = add_w[WIDTH-1:0];
        sc_ofl = sign ? (A[WIDTH-1] == B[WIDTH-1]) &&
                        (add_w[WIDTH-1] != A[WIDTH-1])
                      : add_w[WIDTH];
      end
      4'd1: begin
        sc_out = sub_w[WIDTH-1:0];
        sc_ofl = sign ? (A[WIDTH-1] != B[WIDTH-1]) &&
                        (sub_w[WIDTH-1] != B[WIDTH-1])
                      : sub_w[WIDTH];
      end
      4'd2: sc_out = A & B;
      4'd3: sc_out = A | B;
      4'd4: sc_out = A ^ B;
      4'd5: sc_out = A << sh;
      4'd6: sc_out = A >> sh;
      4'd7: sc_out = $unsigned($signed(A) >>> sh);
      4'd8: sc_out = (A << sh) | (A >> (WIDTH - int'(sh)));
      4'd9: sc_out = (A >> sh) | (A << (WIDTH - int'(sh)));
      4'd10, 4'd11: sc_out = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // hi/lo hold partial product + multiplier, or remainder + dividend/quotient
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_t   = {hi_q, lo_q[WIDTH-1]};
    div_s   = div_t[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      if (div_t >= {1'b0, opnd_q}) begin
        hi_n = div_s;
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = div_t[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = is_it ? ITER : DONE;
      ITER: if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      ofl_q    <= 1'b0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else if (accept) begin
      dz_q <= 1'b0;
      if (is_it) begin
        is_div_q <= Op[0];
        opnd_q   <= Op[0] ? B : A;
        lo_q     <= Op[0] ? A : B;
        hi_q     <= '0;
        cnt_q    <= SHW'(WIDTH-1);
        ill_q    <= 1'b0;
      end else begin
        out_q    <= sc_out;
        out_hi_q <= '0;
        ofl_q    <= sc_ofl;
        zero_q   <= (sc_out == '0);
        ill_q    <= sc_ill;
      end
    end else if (state_q == ITER) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q - SHW'(1);
      if (last) begin
        out_q    <= lo_n;
        out_hi_q <= hi_n;
        ofl_q    <= !is_div_q && (hi_n != '0);
        zero_q   <= (lo_n == '0);
        dz_q     <= is_div_q && (opnd_q == '0);
      end
    end
  end

  assign Out     = out_q;
  assign Out_hi  = out_hi_q;
  assign OFL     = ofl_q;
  assign Zero    = zero_q;
  assign DZ      = dz_q;
  assign Illegal = ill_q;

endmodule
